router_fsm_nport: RTL and testbench

//  Parametrised successor of the 1x4 router control FSM: sequences header decode, payload load,

---
 rtl/router_fsm_nport.sv | 165 ++++++++++++++++
 tb/tb_router_fsm_nport.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/router_fsm_nport.sv
// rtl/router_fsm_nport.sv - control FSM for a 1xNUM_PORTS packet router
// Optional packet/drop statistics counters enabled by defining ROUTER_FSM_STATS_EN.
module router_fsm_nport #(
   parameter int NUM_PORTS = 4,
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 2,
   parameter int WAIT_MAX  = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 pkt_valid,
   input  logic [DATA_W-1:0]    data_in,
   input  logic                 fifo_full,
   input  logic [NUM_PORTS-1:0] fifo_empty,
   input  logic [NUM_PORTS-1:0] soft_reset,
   input  logic                 parity_done,
   input  logic                 low_packet_valid,
   output logic                 write_enb_reg,
   output logic                 detect_add,
   output logic                 ld_state,
   output logic                 laf_state,
   output logic                 lfd_state,
   output logic                 full_state,
   output logic                 rst_int_reg,
   output logic                 busy,
   output logic                 drop_state,
   output logic [ADDR_W-1:0]    dest_addr,
   output logic                 wait_timeout
`ifdef ROUTER_FSM_STATS_EN
   ,
   output logic [15:0]          pkt_cnt,
   output logic [15:0]          drop_cnt
`endif
);

   localparam int CNT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

   typedef enum logic [3:0] {
      S_DECODE,
      S_LFD,
      S_LD,
      S_FULL,
      S_LAF,
      S_LP,
      S_CPE,
      S_WAIT,
      S_DROP
   } state_t;

   state_t            state, next_state;
   logic [ADDR_W-1:0] next_dest;
   logic [CNT_W-1:0]  wait_cnt;
   logic [ADDR_W-1:0] hdr_addr;
   logic              hdr_hit, hdr_empty;
   logic              sel_empty, sel_soft;
   logic              wait_hit, abort;
   logic              unused_data;

   assign hdr_addr    = data_in[ADDR_W-1:0];
   assign unused_data = ^data_in[DATA_W-1:ADDR_W];

   // Port lookups compare against each legal index, so an out-of-range address never indexes the vectors.
   always_comb begin
      hdr_hit   = 1'b0;
      hdr_empty = 1'b0;
      sel_empty = 1'b0;
      sel_soft  = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (hdr_addr == ADDR_W'(i)) begin
            hdr_hit   = 1'b1;
            hdr_empty = fifo_empty[i];
         end
         if (dest_addr == ADDR_W'(i)) begin
            sel_empty = fifo_empty[i];
            sel_soft  = soft_reset[i];
         end
      end
   end

   always_comb begin
      next_state = state;
      next_dest  = dest_addr;
      wait_hit   = 1'b0;
      case (state)
         S_DECODE: begin
            if (pkt_valid) begin
               next_dest = hdr_addr;
               if (!hdr_hit)       next_state = S_DROP;
               else if (hdr_empty) next_state = S_LFD;
               else                next_state = S_WAIT;
            end
         end
         S_LFD:  next_state = S_LD;
         S_LD: begin
            if (fifo_full)       next_state = S_FULL;
            else if (!pkt_valid) next_state = S_LP;
         end
         S_FULL: if (!fifo_full) next_state = S_LAF;
         S_LAF: begin
            if (parity_done)           next_state = S_DECODE;
            else if (low_packet_valid) next_state = S_LP;
            else                       next_state = S_LD;
         end
         S_LP:   next_state = S_CPE;
         S_CPE:  next_state = fifo_full ? S_FULL : S_DECODE;
         S_WAIT: begin
            if (sel_empty) begin
               next_state = S_LFD;
            end else if ((WAIT_MAX > 0) && (wait_cnt == WAIT_LAST)) begin
               next_state = S_DECODE;
               wait_hit   = 1'b1;
            end
         end
         S_DROP: if (!pkt_valid) next_state = S_DECODE;
         default: next_state = S_DECODE;
      endcase
      // Read-side soft reset of the selected port aborts any packet in flight.
      abort = sel_soft && (state != S_DECODE) && (state != S_DROP);
      if (abort) begin
         next_state = S_DECODE;
         wait_hit   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_DECODE;
         dest_addr    <= '0;
         wait_cnt     <= '0;
         wait_timeout <= 1'b0;
      end else begin
         state        <= next_state;
         dest_addr    <= next_dest;
         wait_cnt     <= ((state == S_WAIT) && (next_state == S_WAIT)) ? wait_cnt + 1'b1 : '0;
         wait_timeout <= wait_hit;
      end
   end

`ifdef ROUTER_FSM_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         pkt_cnt  <= '0;
         drop_cnt <= '0;
      end else begin
         if ((state == S_CPE) && !abort && (pkt_cnt != 16'hFFFF))
            pkt_cnt <= pkt_cnt + 16'd1;
         if ((state == S_DROP) && !pkt_valid && (drop_cnt != 16'hFFFF))
            drop_cnt <= drop_cnt + 16'd1;
      end
   end
`endif

   assign detect_add    = (state == S_DECODE);
   assign lfd_state     = (state == S_LFD);
   assign ld_state      = (state == S_LD);
   assign full_state    = (state == S_FULL);
   assign laf_state     = (state == S_LAF);
   assign rst_int_reg   = (state == S_CPE);
   assign drop_state    = (state == S_DROP);
   assign write_enb_reg = (state == S_LD) || (state == S_LAF) || (state == S_LP);
   assign busy          = (state == S_LFD) || (state == S_FULL) || (state == S_LAF) ||
                          (state == S_LP)  || (state == S_CPE)  || (state == S_WAIT);

endmodule

// File: tb/tb_router_fsm_nport.sv
// tb/tb_router_fsm_nport.sv - directed bench for router_fsm_nport (3 ports, WAIT_MAX=4)
module tb_router_fsm_nport;

   // {detect_add, lfd, ld, full, laf, rst_int_reg, write_enb_reg, busy, drop_state, wait_timeout}
   localparam logic [9:0] O_DEC  = 10'b1000000000;
   localparam logic [9:0] O_DECT = 10'b1000000001;
   localparam logic [9:0] O_LFD  = 10'b0100000100;
   localparam logic [9:0] O_LD   = 10'b0010001000;
   localparam logic [9:0] O_FULL = 10'b0001000100;
   localparam logic [9:0] O_LAF  = 10'b0000101100;
   localparam logic [9:0] O_LP   = 10'b0000001100;
   localparam logic [9:0] O_CPE  = 10'b0000010100;
   localparam logic [9:0] O_WAIT = 10'b0000000100;
   localparam logic [9:0] O_DROP = 10'b0000000010;

   logic       clk = 1'b0;
   logic       reset, pkt_valid, fifo_full, parity_done, low_packet_valid;
   logic [7:0] data_in;
   logic [2:0] fifo_empty, soft_reset;
   logic       write_enb_reg, detect_add, ld_state, laf_state, lfd_state, full_state;
   logic       rst_int_reg, busy, drop_state, wait_timeout;
   logic [1:0] dest_addr;
   logic [9:0] outs;
`ifdef ROUTER_FSM_STATS_EN
   logic [15:0] pkt_cnt, drop_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   router_fsm_nport #(.NUM_PORTS(3), .DATA_W(8), .ADDR_W(2), .WAIT_MAX(4)) dut (
      .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
      .parity_done(parity_done), .low_packet_valid(low_packet_valid),
      .write_enb_reg(write_enb_reg), .detect_add(detect_add), .ld_state(ld_state),
      .laf_state(laf_state), .lfd_state(lfd_state), .full_state(full_state),
      .rst_int_reg(rst_int_reg), .busy(busy), .drop_state(drop_state),
      .dest_addr(dest_addr), .wait_timeout(wait_timeout)
`ifdef ROUTER_FSM_STATS_EN
      , .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
`endif
   );

   assign outs = {detect_add, lfd_state, ld_state, full_state, laf_state,
                  rst_int_reg, write_enb_reg, busy, drop_state, wait_timeout};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [9:0] exp_o, input logic [1:0] exp_d);
      n_vec++;
      assert (outs === exp_o) else begin
         n_err++;
         $error("FAIL %s outputs: got %b expected %b", tag, outs, exp_o);
      end
      n_vec++;
      assert (dest_addr === exp_d) else begin
         n_err++;
         $error("FAIL %s dest_addr: got %0d expected %0d", tag, dest_addr, exp_d);
      end
   endtask

   initial begin
      reset = 1'b1; pkt_valid = 1'b0; data_in = 8'h00; fifo_full = 1'b0;
      fifo_empty = 3'b111; soft_reset = 3'b000; parity_done = 1'b0; low_packet_valid = 1'b0;
      tick(); tick();
      chk("reset", O_DEC, 2'd0);
      reset = 1'b0;

      // normal packet to port 2
      pkt_valid = 1'b1; data_in = 8'h02;
      tick(); chk("norm_lfd", O_LFD, 2'd2);
      data_in = 8'hA1; tick(); chk("norm_ld1", O_LD, 2'd2);
      data_in = 8'hA2; tick(); chk("norm_ld2", O_LD, 2'd2);
      data_in = 8'hA3; tick(); chk("norm_ld3", O_LD, 2'd2);
      pkt_valid = 1'b0; data_in = 8'h5C;
      tick(); chk("norm_lp", O_LP, 2'd2);
      tick(); chk("norm_cpe", O_CPE, 2'd2);
      tick(); chk("norm_dec", O_DEC, 2'd2);

      // full stall on port 1
      pkt_valid = 1'b1; data_in = 8'h01;
      tick(); chk("stall_lfd", O_LFD, 2'd1);
      data_in = 8'h11; tick(); chk("stall_ld", O_LD, 2'd1);
      fifo_full = 1'b1;
      tick(); chk("stall_full1", O_FULL, 2'd1);
      tick(); chk("stall_full2", O_FULL, 2'd1);
      tick(); chk("stall_full3", O_FULL, 2'd1);
      fifo_full = 1'b0;
      tick(); chk("stall_laf", O_LAF, 2'd1);
      tick(); chk("stall_ld_again", O_LD, 2'd1);
      pkt_valid = 1'b0;
      tick(); chk("stall_lp", O_LP, 2'd1);
      tick(); chk("stall_cpe", O_CPE, 2'd1);
      tick(); chk("stall_dec", O_DEC, 2'd1);

      // low_packet_valid, CPE with full, parity_done exit on port 0
      pkt_valid = 1'b1; data_in = 8'h00;
      tick(); chk("lpv_lfd", O_LFD, 2'd0);
      tick(); chk("lpv_ld", O_LD, 2'd0);
      fifo_full = 1'b1; tick(); chk("lpv_full", O_FULL, 2'd0);
      fifo_full = 1'b0; low_packet_valid = 1'b1; pkt_valid = 1'b0;
      tick(); chk("lpv_laf", O_LAF, 2'd0);
      tick(); chk("lpv_lp", O_LP, 2'd0);
      low_packet_valid = 1'b0; fifo_full = 1'b1;
      tick(); chk("lpv_cpe", O_CPE, 2'd0);
      tick(); chk("cpe_full", O_FULL, 2'd0);
      fifo_full = 1'b0; tick(); chk("cpe_laf", O_LAF, 2'd0);
      parity_done = 1'b1; tick(); chk("laf_pdone_dec", O_DEC, 2'd0);
      parity_done = 1'b0;

      // wait-till-empty timeout on port 1
      fifo_empty = 3'b101; pkt_valid = 1'b1; data_in = 8'h01;
      tick(); chk("wait1", O_WAIT, 2'd1);
      pkt_valid = 1'b0;
      tick(); chk("wait2", O_WAIT, 2'd1);
      tick(); chk("wait3", O_WAIT, 2'd1);
      tick(); chk("wait4", O_WAIT, 2'd1);
      tick(); chk("wait_timeout", O_DECT, 2'd1);
      tick(); chk("wait_pulse_end", O_DEC, 2'd1);

      // port 1 drains during the second wait cycle
      pkt_valid = 1'b1; data_in = 8'h01;
      tick(); chk("wait_b1", O_WAIT, 2'd1);
      pkt_valid = 1'b0;
      tick(); chk("wait_b2", O_WAIT, 2'd1);
      fifo_empty = 3'b111;
      tick(); chk("wait_lfd", O_LFD, 2'd1);
      tick(); chk("wait_ld", O_LD, 2'd1);
      tick(); chk("wait_lp", O_LP, 2'd1);
      tick(); chk("wait_cpe", O_CPE, 2'd1);
      tick(); chk("wait_dec", O_DEC, 2'd1);

      // invalid address 3 is dropped
      pkt_valid = 1'b1; data_in = 8'h03;
      tick(); chk("drop_hdr", O_DROP, 2'd3);
      for (int i = 0; i < 4; i++) begin
         data_in = 8'(8'hD0 + i);
         soft_reset = 3'b111;
         tick(); chk("drop_body", O_DROP, 2'd3);
      end
      soft_reset = 3'b000; pkt_valid = 1'b0;
      tick(); chk("drop_dec", O_DEC, 2'd3);
      tick(); chk("drop_dec_hold", O_DEC, 2'd3);

      // soft reset on port 0 mid-payload; port 2 ignored
      pkt_valid = 1'b1; data_in = 8'h00;
      tick(); chk("srst_lfd", O_LFD, 2'd0);
      tick(); chk("srst_ld", O_LD, 2'd0);
      soft_reset = 3'b100;
      tick(); chk("srst_other_ignored", O_LD, 2'd0);
      soft_reset = 3'b001;
      tick(); chk("srst_abort", O_DEC, 2'd0);
      soft_reset = 3'b000; pkt_valid = 1'b0;
      tick(); chk("srst_idle", O_DEC, 2'd0);

`ifdef ROUTER_FSM_STATS_EN
      n_vec++;
      assert (pkt_cnt === 16'd4) else begin
         n_err++;
         $error("FAIL pkt_cnt: got %0d expected %0d", pkt_cnt, 4);
      end
      n_vec++;
      assert (drop_cnt === 16'd1) else begin
         n_err++;
         $error("FAIL drop_cnt: got %0d expected %0d", drop_cnt, 1);
      end
`endif

      // reset beats soft reset and clears dest_addr mid-packet
      pkt_valid = 1'b1; data_in = 8'h02;
      tick(); chk("rst_mid_lfd", O_LFD, 2'd2);
      reset = 1'b1; soft_reset = 3'b100;
      tick(); chk("rst_mid", O_DEC, 2'd0);
      reset = 1'b0; soft_reset = 3'b000; pkt_valid = 1'b0;
      tick(); chk("rst_mid_idle", O_DEC, 2'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
